// File: rtl/riscv_arb_pkg.sv
// Shared encodings for the instruction/data memory port arbiter.
package riscv_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        GNT_INST = 1'b0,
        GNT_DATA = 1'b1
    } arb_gnt_t;

    localparam logic [31:0] RV_NOP = 32'h0000_0013;

endpackage

// File: rtl/mem_arb_watchdog.sv
// WAIT-state cycle counter; expired is high on the TIMEOUT-th consecutive WAIT cycle.
// Only instantiated when MEM_ARB_TIMEOUT_EN is defined.
module mem_arb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg <= '0;
        end else if (!run) begin
            cnt_reg <= '0;
        end else if (!expired) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    assign expired = run && (cnt_reg == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the core's fetch and data ports onto one single-port memory; data wins,
// bounded by MAX_DATA_BURST. Optional WAIT timeout enabled by macro MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
    import riscv_arb_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int MAX_DATA_BURST = 4,
    parameter int TIMEOUT        = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_req_i,
    input  logic [ADDR_W-1:0] inst_addr_i,
    output logic [DATA_W-1:0] inst_rdata_o,
    output logic              inst_ack_o,
    input  logic              data_req_i,
    input  logic              data_we_i,
    input  logic [3:0]        data_be_i,
    input  logic [ADDR_W-1:0] data_addr_i,
    input  logic [DATA_W-1:0] data_wdata_i,
    output logic [DATA_W-1:0] data_rdata_o,
    output logic              data_ack_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_be_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i,
    output logic              stall_o,
    output logic              busy_o,
    output logic              err_o
);

    localparam logic [3:0] BURST_LIMIT = MAX_DATA_BURST[3:0];

    arb_state_t        state_reg, state_next;
    arb_gnt_t          gnt_reg, gnt_next;
    logic [3:0]        burst_cnt_reg, burst_cnt_next;
    logic              mem_req_reg, mem_req_next;
    logic              mem_we_reg, mem_we_next;
    logic [3:0]        mem_be_reg, mem_be_next;
    logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
    logic [DATA_W-1:0] mem_wdata_reg, mem_wdata_next;
    logic [DATA_W-1:0] inst_rdata_reg, inst_rdata_next;
    logic [DATA_W-1:0] data_rdata_reg, data_rdata_next;
    logic              abort;
    logic              grant_data;

`ifdef MEM_ARB_TIMEOUT_EN
    logic wd_expired;
    logic err_reg;

    mem_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .run     (state_reg == WAIT),
        .expired (wd_expired)
    );

    // A late ack on the expiry cycle still wins over the abort.
    assign abort = wd_expired && !mem_ack_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_reg <= 1'b0;
        end else if (state_reg == WAIT && abort) begin
            err_reg <= 1'b1;
        end
    end

    assign err_o = err_reg;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
    assign abort          = 1'b0;
    assign err_o          = 1'b0;
`endif

    assign grant_data = data_req_i && ((burst_cnt_reg < BURST_LIMIT) || !inst_req_i);

    always_comb begin
        state_next      = state_reg;
        gnt_next        = gnt_reg;
        burst_cnt_next  = burst_cnt_reg;
        mem_req_next    = mem_req_reg;
        mem_we_next     = mem_we_reg;
        mem_be_next     = mem_be_reg;
        mem_addr_next   = mem_addr_reg;
        mem_wdata_next  = mem_wdata_reg;
        inst_rdata_next = inst_rdata_reg;
        data_rdata_next = data_rdata_reg;

        case (state_reg)
            IDLE: begin
                if (grant_data) begin
                    state_next     = WAIT;
                    gnt_next       = GNT_DATA;
                    mem_req_next   = 1'b1;
                    mem_we_next    = data_we_i;
                    mem_be_next    = data_be_i;
                    mem_addr_next  = data_addr_i;
                    mem_wdata_next = data_wdata_i;
                    burst_cnt_next = inst_req_i ? burst_cnt_reg + 4'd1 : 4'd0;
                end else if (inst_req_i) begin
                    state_next     = WAIT;
                    gnt_next       = GNT_INST;
                    mem_req_next   = 1'b1;
                    mem_we_next    = 1'b0;
                    mem_be_next    = 4'hF;
                    mem_addr_next  = inst_addr_i;
                    mem_wdata_next = '0;
                    burst_cnt_next = 4'd0;
                end else begin
                    burst_cnt_next = 4'd0;
                end
            end
            WAIT: begin
                if (mem_ack_i || abort) begin
                    state_next   = RESP;
                    mem_req_next = 1'b0;
                    if (gnt_reg == GNT_INST) begin
                        inst_rdata_next = abort ? DATA_W'(RV_NOP) : mem_rdata_i;
                    end else if (!mem_we_reg) begin
                        data_rdata_next = abort ? '0 : mem_rdata_i;
                    end
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next   = IDLE;
                mem_req_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            gnt_reg        <= GNT_INST;
            burst_cnt_reg  <= 4'd0;
            mem_req_reg    <= 1'b0;
            mem_we_reg     <= 1'b0;
            mem_be_reg     <= 4'h0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            inst_rdata_reg <= '0;
            data_rdata_reg <= '0;
        end else begin
            state_reg      <= state_next;
            gnt_reg        <= gnt_next;
            burst_cnt_reg  <= burst_cnt_next;
            mem_req_reg    <= mem_req_next;
            mem_we_reg     <= mem_we_next;
            mem_be_reg     <= mem_be_next;
            mem_addr_reg   <= mem_addr_next;
            mem_wdata_reg  <= mem_wdata_next;
            inst_rdata_reg <= inst_rdata_next;
            data_rdata_reg <= data_rdata_next;
        end
    end

    assign mem_req_o    = mem_req_reg;
    assign mem_we_o     = mem_we_reg;
    assign mem_be_o     = mem_be_reg;
    assign mem_addr_o   = mem_addr_reg;
    assign mem_wdata_o  = mem_wdata_reg;
    assign inst_rdata_o = inst_rdata_reg;
    assign data_rdata_o = data_rdata_reg;
    assign inst_ack_o   = (state_reg == RESP) && (gnt_reg == GNT_INST);
    assign data_ack_o   = (state_reg == RESP) && (gnt_reg == GNT_DATA);
    assign busy_o       = (state_reg != IDLE);
    assign stall_o      = (inst_req_i && !inst_ack_o) || (data_req_i && !data_ack_o);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a latency-programmable memory model.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req_i = 1'b0;
    logic [31:0] inst_addr_i = '0;
    logic [31:0] inst_rdata_o;
    logic        inst_ack_o;
    logic        data_req_i = 1'b0;
    logic        data_we_i = 1'b0;
    logic [3:0]  data_be_i = 4'h0;
    logic [31:0] data_addr_i = '0;
    logic [31:0] data_wdata_i = '0;
    logic [31:0] data_rdata_o;
    logic        data_ack_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i = '0;
    logic        mem_ack_i = 1'b0;
    logic        stall_o;
    logic        busy_o;
    logic        err_o;

    int n_vec = 0;
    int n_bad = 0;
    int lat = 0;
    bit hang = 1'b0;
    int age = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .MAX_DATA_BURST (4),
        .TIMEOUT        (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .inst_req_i   (inst_req_i),
        .inst_addr_i  (inst_addr_i),
        .inst_rdata_o (inst_rdata_o),
        .inst_ack_o   (inst_ack_o),
        .data_req_i   (data_req_i),
        .data_we_i    (data_we_i),
        .data_be_i    (data_be_i),
        .data_addr_i  (data_addr_i),
        .data_wdata_i (data_wdata_i),
        .data_rdata_o (data_rdata_o),
        .data_ack_o   (data_ack_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_be_o     (mem_be_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rdata_i  (mem_rdata_i),
        .mem_ack_i    (mem_ack_i),
        .stall_o      (stall_o),
        .busy_o       (busy_o),
        .err_o        (err_o)
    );

    // Memory acks `lat` cycles after mem_req_o first appears; read data derives from address.
    always @(posedge clk) begin
        if (mem_req_o && !mem_ack_i) age <= age + 1;
        else                         age <= 0;
    end

    always @(negedge clk) begin
        mem_ack_i   = mem_req_o && !hang && (age == lat);
        mem_rdata_i = (mem_addr_o == 32'h100) ? 32'hDEAD_BEEF : {16'hC0DE, mem_addr_o[15:0]};
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(output logic [1:0] seen);
        seen = 2'b00;
        for (int i = 0; i < 20 && seen == 2'b00; i++) begin
            cyc();
            seen = {inst_ack_o, data_ack_o};
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [1:0] seen;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst mem_req", mem_req_o, 0);
        check_val("rst busy", busy_o, 0);
        check_val("rst stall", stall_o, 0);
        check_val("rst acks", {inst_ack_o, data_ack_o}, 0);
        check_val("rst err", err_o, 0);
        check_val("rst inst_rdata", inst_rdata_o, 0);
        rst = 1'b1;
        cyc();

        // single load, memory acks two cycles after mem_req_o
        lat = 2;
        data_addr_i = 32'h100; data_we_i = 1'b0; data_req_i = 1'b1;
        cyc();
        check_val("ld c1 mem_req", mem_req_o, 1);
        check_val("ld c1 addr", mem_addr_o, 32'h100);
        check_val("ld c1 we", mem_we_o, 0);
        check_val("ld c1 stall", stall_o, 1);
        cyc(); cyc();
        check_val("ld c3 ack", data_ack_o, 0);
        check_val("ld c3 mem_req", mem_req_o, 1);
        cyc();
        check_val("ld c4 ack", data_ack_o, 1);
        check_val("ld c4 rdata", data_rdata_o, 32'hDEAD_BEEF);
        check_val("ld c4 mem_req", mem_req_o, 0);
        check_val("ld c4 stall", stall_o, 0);
        data_req_i = 1'b0;
        cyc();
        check_val("ld c5 stall", stall_o, 0);
        check_val("ld c5 busy", busy_o, 0);
        check_val("ld c5 rdata hold", data_rdata_o, 32'hDEAD_BEEF);

        // simultaneous requests, zero-latency memory
        lat = 0;
        inst_addr_i = 32'h200; data_addr_i = 32'h300;
        inst_req_i = 1'b1; data_req_i = 1'b1;
        cyc();
        check_val("sim c1 addr", mem_addr_o, 32'h300);
        cyc();
        check_val("sim c2 acks", {inst_ack_o, data_ack_o}, 2'b01);
        check_val("sim c2 rdata", data_rdata_o, 32'hC0DE_0300);
        check_val("sim c2 stall", stall_o, 1);
        data_req_i = 1'b0;
        cyc();
        check_val("sim c3 busy", busy_o, 0);
        cyc();
        check_val("sim c4 addr", mem_addr_o, 32'h200);
        check_val("sim c4 be", mem_be_o, 4'hF);
        check_val("sim c4 we", mem_we_o, 0);
        cyc();
        check_val("sim c5 acks", {inst_ack_o, data_ack_o}, 2'b10);
        check_val("sim c5 rdata", inst_rdata_o, 32'hC0DE_0200);
        inst_req_i = 1'b0;
        cyc();
        check_val("sim c6 stall", stall_o, 0);

        // starvation guard: four data grants then one fetch, repeating
        inst_addr_i = 32'h400; data_addr_i = 32'h500;
        inst_req_i = 1'b1; data_req_i = 1'b1;
        for (int t = 0; t < 10; t++) begin
            wait_ack(seen);
            check_val($sformatf("burst t%0d", t), seen, (t % 5 == 4) ? 2'b10 : 2'b01);
        end
        inst_req_i = 1'b0; data_req_i = 1'b0;
        cyc();
        check_val("burst idle", busy_o, 0);

        // store with payload disturbed during WAIT
        lat = 1;
        data_addr_i = 32'h600; data_we_i = 1'b1; data_be_i = 4'b0011;
        data_wdata_i = 32'h1234_5678; data_req_i = 1'b1;
        cyc();
        check_val("st c1 we", mem_we_o, 1);
        check_val("st c1 be", mem_be_o, 4'b0011);
        check_val("st c1 wdata", mem_wdata_o, 32'h1234_5678);
        check_val("st c1 addr", mem_addr_o, 32'h600);
        data_wdata_i = 32'hFFFF_FFFF; data_be_i = 4'hF; data_addr_i = 32'h700; data_we_i = 1'b0;
        cyc();
        check_val("st c2 wdata", mem_wdata_o, 32'h1234_5678);
        check_val("st c2 be", mem_be_o, 4'b0011);
        check_val("st c2 addr", mem_addr_o, 32'h600);
        cyc();
        check_val("st c3 ack", data_ack_o, 1);
        check_val("st c3 rdata hold", data_rdata_o, 32'hC0DE_0500);
        data_req_i = 1'b0;
        cyc();

        // reset while a fetch is in WAIT
        lat = 3;
        inst_addr_i = 32'h800; inst_req_i = 1'b1;
        cyc();
        check_val("rw c1 mem_req", mem_req_o, 1);
        cyc();
        rst = 1'b0;
        #1;
        check_val("rw mem_req", mem_req_o, 0);
        check_val("rw busy", busy_o, 0);
        check_val("rw acks", {inst_ack_o, data_ack_o}, 0);
        check_val("rw inst_rdata", inst_rdata_o, 0);
        cyc();
        rst = 1'b1;
        wait_ack(seen);
        check_val("rw after acks", seen, 2'b10);
        check_val("rw after rdata", inst_rdata_o, 32'hC0DE_0800);
        inst_req_i = 1'b0;
        cyc();

`ifdef MEM_ARB_TIMEOUT_EN
        // memory never answers: NOP returned after TIMEOUT WAIT cycles
        hang = 1'b1;
        inst_addr_i = 32'h900; inst_req_i = 1'b1;
        repeat (8) cyc();
        check_val("to c8 ack", inst_ack_o, 0);
        check_val("to c8 mem_req", mem_req_o, 1);
        check_val("to c8 err", err_o, 0);
        cyc();
        check_val("to c9 ack", inst_ack_o, 1);
        check_val("to c9 rdata", inst_rdata_o, 32'h0000_0013);
        check_val("to c9 err", err_o, 1);
        check_val("to c9 mem_req", mem_req_o, 0);
        inst_req_i = 1'b0; hang = 1'b0;
        cyc();
        check_val("to c10 err sticky", err_o, 1);
        check_val("to c10 busy", busy_o, 0);
`else
        check_val("err tied low", err_o, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the core's instruction-fetch port and data port.
- Sits between the riscv core (inst_*/data_* buses) and the memory. Carries each transaction through a req/ack handshake.
- Data wins on conflict. A burst limit stops instruction fetch from being starved.
- Drives stall_o to freeze the core while any of its requests is unserved.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.
- MAX_DATA_BURST, 4, consecutive data grants allowed while inst_req_i is pending; range 1..15.
- TIMEOUT, 255, WAIT-state cycles before abort; used only with the timeout feature.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- inst_req_i  in  1  fetch request, level; held until inst_ack_o.
- inst_addr_i  in  ADDR_W  fetch address.
- inst_rdata_o  out  DATA_W  fetched instruction, valid while inst_ack_o=1.
- inst_ack_o  out  1  one-cycle completion pulse.
- data_req_i  in  1  data request, level; held until data_ack_o.
- data_we_i  in  1  1=store, 0=load.
- data_be_i  in  4  byte enables for stores.
- data_addr_i  in  ADDR_W  data address.
- data_wdata_i  in  DATA_W  store data.
- data_rdata_o  out  DATA_W  load data, valid while data_ack_o=1.
- data_ack_o  out  1  one-cycle completion pulse.
- mem_req_o  out  1  memory request, registered.
- mem_we_o  out  1  memory write enable.
- mem_be_o  out  4  memory byte enables.
- mem_addr_o  out  ADDR_W  memory address.
- mem_wdata_o  out  DATA_W  memory write data.
- mem_rdata_i  in  DATA_W  memory read data, valid with mem_ack_i.
- mem_ack_i  in  1  memory completion, variable latency ≥0 cycles after mem_req_o.
- stall_o  out  1  core stall.
- busy_o  out  1  state != IDLE.
- err_o  out  1  sticky timeout error.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; all outputs 0; burst counter 0; err_o cleared.
- Reset mid-transaction drops mem_req_o immediately. The memory must tolerate an abandoned request.
- FSM states are IDLE, WAIT, RESP.
- IDLE:
  - If data_req_i and (burst_cnt<MAX_DATA_BURST or !inst_req_i): grant data, latch payload into mem_* registers, go to WAIT.
  - Else if inst_req_i: grant inst (mem_we_o=0, mem_be_o=4'hF), go to WAIT.
  - Else stay in IDLE.
- burst_cnt:
  - Increments on each data grant made while inst_req_i=1.
  - Clears on any inst grant, or when inst_req_i=0 in IDLE.
- WAIT:
  - mem_req_o=1 with mem_* payload held stable.
  - On mem_ack_i=1: capture mem_rdata_i into the granted port's rdata_o, drop mem_req_o, go to RESP.
- RESP:
  - Granted port's ack_o=1 for exactly this cycle. No new grant is made.
  - Next state is IDLE.
- Timing:
  - Request seen in IDLE at cycle 0 → mem_req_o=1 at cycle 1.
  - mem_ack_i at cycle k≥1 → ack_o=1 at cycle k+1.
  - IDLE again at k+2. Minimum 3 cycles per transaction.
- Requester rule: a req still high in the cycle after its ack is a new request.
- On stores, data_rdata_o holds its previous value. rdata_o outputs hold their value between acks.
- mem_ack_i is ignored outside WAIT.
- stall_o = (inst_req_i & ~inst_ack_o) | (data_req_i & ~data_ack_o), combinational.
- Payload changes on inst_*/data_* during WAIT have no effect, because the payload is latched.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- Defined:
  - A WAIT cycle counter runs. It reaching TIMEOUT with no mem_ack_i forces mem_req_o=0 and moves to RESP.
  - ack_o pulses with rdata = 32'h0000_0013 (NOP) for inst, or 0 for data.
  - err_o sets and stays set until reset.
- Undefined: WAIT lasts indefinitely and err_o is tied 0.

Decomposition:
- Package riscv_arb_pkg holds:
  - state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2);
  - grant encoding (GNT_INST=1'b0, GNT_DATA=1'b1);
  - RV_NOP=32'h0000_0013.
- One sub-module, mem_arb_watchdog (the timeout counter), instantiated only under MEM_ARB_TIMEOUT_EN.

Test Plan:
- Single load: data_req_i=1, data_addr_i=32'h100, memory acks 2 cycles after mem_req_o with 32'hDEADBEEF → mem_addr_o=32'h100 from cycle 1; data_ack_o=1 and data_rdata_o=32'hDEADBEEF at cycle 4; stall_o=0 from cycle 5.
- Simultaneous requests: inst_req_i and data_req_i both rise at cycle 0, zero-latency memory → data granted first (data_ack_o at cycle 2), inst granted next (inst_ack_o at cycle 5).
- Starvation guard: data_req_i held high continuously with inst_req_i=1 → exactly 4 data grants, then 1 inst grant, then the pattern repeats.
- Store: data_we_i=1, data_be_i=4'b0011, data_wdata_i=32'h1234_5678 → mem_we_o=1, mem_be_o=4'b0011, mem_wdata_o=32'h1234_5678 while in WAIT; data_rdata_o unchanged.
- Reset mid-WAIT: drive rst=0 while mem_req_o=1 → mem_req_o, stall-related acks and busy_o go 0 immediately; after release, a fresh inst_req_i completes normally.
- Timeout (MEM_ARB_TIMEOUT_EN, TIMEOUT=8): inst request, memory never acks → inst_ack_o pulses with inst_rdata_o=32'h0000_0013 9 cycles after grant; err_o=1 and stays set.
